// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_pkg
// Purpose  : Shared widths, opcode patterns and control-flow decode for the
//            14-bit MCU core.
// Revision : 1.0 - initial release
// ============================================================================
package mcu_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 14;

  localparam logic [INSTR_W-1:0] OP_JMP_MASK   = 14'h3800;
  localparam logic [INSTR_W-1:0] OP_GOTO       = 14'h2800;
  localparam logic [INSTR_W-1:0] OP_CALL       = 14'h2000;
  localparam logic [INSTR_W-1:0] OP_RETURN     = 14'h0008;
  localparam logic [INSTR_W-1:0] OP_RETFIE     = 14'h0009;
  localparam logic [INSTR_W-1:0] OP_RETLW_MASK = 14'h3C00;
  localparam logic [INSTR_W-1:0] OP_RETLW      = 14'h3400;

  typedef enum logic [1:0] {
    FLOW_SEQ  = 2'd0,
    FLOW_JUMP = 2'd1,
    FLOW_CALL = 2'd2,
    FLOW_RET  = 2'd3
  } flow_t;

  function automatic flow_t decode_flow(input logic [INSTR_W-1:0] word);
    flow_t f;
    f = FLOW_SEQ;
    if ((word & OP_JMP_MASK) == OP_GOTO)
      f = FLOW_JUMP;
    else if ((word & OP_JMP_MASK) == OP_CALL)
      f = FLOW_CALL;
    else if (word == OP_RETURN || word == OP_RETFIE ||
             (word & OP_RETLW_MASK) == OP_RETLW)
      f = FLOW_RET;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : pic_return_stack
// Purpose  : Circular return-address stack with saturating depth and
//            registered overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module pic_return_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] C_FULL = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  r_mem [STACK_DEPTH];
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_dec;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_ptr_dec = r_ptr - PTR_W'(1);
  assign w_full    = (r_depth == C_FULL);
  assign w_empty   = (r_depth == '0);
  assign w_push    = push && !hold;
  assign w_pop     = pop && !hold && !push;
  assign pop_data  = r_mem[w_ptr_dec];
  assign ovf       = r_ovf;
  assign unf       = r_unf;

  // Entries are deliberately left unreset; only pointer and depth matter.
  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_mem[r_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!hold) begin
      r_ovf <= w_push && w_full;
      r_unf <= w_pop && w_empty;
      if (w_push) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (!w_full)
          r_depth <= r_depth + DEPTH_W'(1);
      end else if (w_pop) begin
        r_ptr <= w_ptr_dec;
        if (!w_empty)
          r_depth <= r_depth - DEPTH_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pic_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pic_fetch_unit
// Purpose  : Instruction fetch front end: PC, instruction register and local
//            resolution of GOTO/CALL/RETURN/RETLW/RETFIE.
// Revision : 1.0 - initial release
// ============================================================================
module pic_fetch_unit #(
  parameter int                ADDR_W       = mcu_pkg::ADDR_W,
  parameter int                INSTR_W      = mcu_pkg::INSTR_W,
  parameter int                STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr_out,
  input  logic [INSTR_W-1:0] rom_data_in,
  input  logic               stall,
  input  logic               skip_req,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_addr,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               stk_ovf,
  output logic               stk_unf
);

  import mcu_pkg::*;

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_ir_valid;
  logic [ADDR_W-1:0]  r_ir_pc;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [ADDR_W-1:0]  w_pop_data;
  flow_t              w_flow;
  logic               w_decode;
  logic               w_push;
  logic               w_pop;
  logic               w_hold;

  assign rom_addr_out = r_pc;
  assign ir_out       = r_ir;
  assign ir_valid     = r_ir_valid;
  assign ir_pc        = r_ir_pc;

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_flow   = decode_flow(rom_data_in);
  // Only a word that reaches decode may touch the stack.
  assign w_decode = !pc_load && !stall && !skip_req;
  assign w_push   = w_decode && (w_flow == FLOW_CALL);
  assign w_pop    = w_decode && (w_flow == FLOW_RET);
  assign w_hold   = stall && !pc_load;

  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_flow)
      FLOW_JUMP, FLOW_CALL: w_pc_next = rom_data_in[ADDR_W-1:0];
      FLOW_RET:             w_pc_next = w_pop_data;
      default:              w_pc_next = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_ir_pc    <= '0;
    end else if (pc_load) begin
      r_pc       <= pc_load_addr;
      r_ir_valid <= 1'b0;
    end else if (!stall) begin
      r_ir    <= rom_data_in;
      r_ir_pc <= r_pc;
      if (skip_req) begin
        r_ir_valid <= 1'b0;
        r_pc       <= w_pc_inc;
      end else begin
        r_ir_valid <= 1'b1;
        r_pc       <= w_pc_next;
      end
    end
  end

  pic_return_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .hold      (w_hold),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .pop_data  (w_pop_data),
    .ovf       (stk_ovf),
    .unf       (stk_unf)
  );

endmodule
`default_nettype wire

// File: tb/tb_pic_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_fetch_unit
// Purpose  : Self-checking bench for pic_fetch_unit with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, skip_req, pc_load;
  logic [10:0] pc_load_addr;
  logic [10:0] rom_addr_out;
  logic [13:0] rom_data_in;
  logic [13:0] ir_out;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic        stk_ovf, stk_unf;

  logic [13:0] rom [0:2047];
  assign rom_data_in = rom[rom_addr_out];

  int checks = 0;
  int errors = 0;

  pic_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .rom_addr_out (rom_addr_out),
    .rom_data_in  (rom_data_in),
    .stall        (stall),
    .skip_req     (skip_req),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .ir_out       (ir_out),
    .ir_valid     (ir_valid),
    .ir_pc        (ir_pc),
    .stk_ovf      (stk_ovf),
    .stk_unf      (stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, modulo arithmetic, array stack.
  int m_pc, m_ir, m_v, m_irpc, m_ptr, m_depth, m_ovf, m_unf;
  int m_stack [8];
  bit m_known = 0;

  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_pc = 0; m_ir = 0; m_v = 0; m_irpc = 0;
      m_ptr = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
      m_known = 1;
    end else if (m_known) begin
      w = int'(rom[m_pc]);
      if (pc_load) begin
        m_pc = int'(pc_load_addr); m_v = 0; m_ovf = 0; m_unf = 0;
      end else if (!stall) begin
        m_ir = w; m_irpc = m_pc; m_ovf = 0; m_unf = 0;
        if (skip_req) begin
          m_v = 0; m_pc = (m_pc + 1) % 2048;
        end else begin
          m_v = 1;
          if ((w & 'h3800) == 'h2800) begin
            m_pc = w % 2048;
          end else if ((w & 'h3800) == 'h2000) begin
            m_stack[m_ptr] = (m_pc + 1) % 2048;
            m_ptr = (m_ptr + 1) % 8;
            if (m_depth == 8) m_ovf = 1; else m_depth++;
            m_pc = w % 2048;
          end else if (w == 'h8 || w == 'h9 || (w & 'h3C00) == 'h3400) begin
            m_ptr = (m_ptr + 7) % 8;
            m_pc = m_stack[m_ptr];
            if (m_depth == 0) m_unf = 1; else m_depth--;
          end else begin
            m_pc = (m_pc + 1) % 2048;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("rom_addr", 32'(rom_addr_out), m_pc);
      chk("ir_out",   32'(ir_out),       m_ir);
      chk("ir_valid", 32'(ir_valid),     m_v);
      chk("ir_pc",    32'(ir_pc),        m_irpc);
      chk("stk_ovf",  32'(stk_ovf),      m_ovf);
      chk("stk_unf",  32'(stk_unf),      m_unf);
    end
  end

  task automatic cyc(input logic r, input logic st, input logic sk,
                     input logic ld, input logic [10:0] la);
    reset = r; stall = st; skip_req = sk; pc_load = ld; pc_load_addr = la;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
    rom[11'h000] = 14'h303C;
    rom[11'h001] = 14'h00A4;
    rom[11'h009] = 14'h2804;
    rom[11'h00A] = 14'h2800;
    rom[11'h00B] = 14'h3400;
    rom[11'h010] = 14'h2050;
    rom[11'h050] = 14'h0008;
    rom[11'h123] = 14'h2200;
    // Nine nested calls at 0x100+16k targeting 0x110+16k; returns unwind to 0x111.
    for (int k = 0; k < 9; k++) rom[11'h100 + 11'(16 * k)] = 14'h2000 | 14'(11'h110 + 11'(16 * k));
    rom[11'h190] = 14'h0008;
    for (int k = 2; k < 9; k++) rom[11'h101 + 11'(16 * k)] = 14'h0008;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_addr",  32'(rom_addr_out), 0);
    chk("rst_ir",    32'(ir_out), 0);
    chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_flags", 32'({stk_ovf, stk_unf}), 0);

    cyc(0, 0, 0, 0, 0);
    chk("f0_ir", 32'(ir_out), 32'h303C);
    chk("f0_pc", 32'(ir_pc), 0);
    chk("f0_valid", 32'(ir_valid), 1);
    chk("f0_addr", 32'(rom_addr_out), 1);
    cyc(0, 0, 0, 0, 0);
    chk("f1_ir", 32'(ir_out), 32'h00A4);
    chk("f1_pc", 32'(ir_pc), 1);
    repeat (7) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("goto_ir", 32'(ir_out), 32'h2804);
    chk("goto_addr", 32'(rom_addr_out), 4);
    cyc(0, 0, 0, 1, 11'h00A);
    cyc(0, 0, 0, 0, 0);
    chk("goto0_addr", 32'(rom_addr_out), 0);

    // Nested calls: overflow only on the ninth.
    cyc(0, 0, 0, 1, 11'h100);
    repeat (8) cyc(0, 0, 0, 0, 0);
    chk("call8_ovf", 32'(stk_ovf), 0);
    cyc(0, 0, 0, 0, 0);
    chk("call9_ovf", 32'(stk_ovf), 1);
    chk("call9_addr", 32'(rom_addr_out), 32'h190);
    repeat (8) cyc(0, 0, 0, 0, 0);
    chk("ret8_addr", 32'(rom_addr_out), 32'h111);
    chk("ret8_unf", 32'(stk_unf), 0);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_pulse", 32'(stk_ovf), 0);

    // Simple call/return pair.
    cyc(0, 0, 0, 1, 11'h010);
    cyc(0, 0, 0, 0, 0);
    chk("call_addr", 32'(rom_addr_out), 32'h050);
    cyc(0, 0, 0, 0, 0);
    chk("ret_addr", 32'(rom_addr_out), 32'h011);
    chk("ret_flags", 32'({stk_ovf, stk_unf}), 0);

    // Skipped GOTO, then RETLW on an empty stack.
    cyc(0, 0, 0, 1, 11'h00A);
    cyc(0, 0, 1, 0, 0);
    chk("skip_valid", 32'(ir_valid), 0);
    chk("skip_addr", 32'(rom_addr_out), 32'h00B);
    chk("skip_ir", 32'(ir_out), 32'h2800);
    cyc(0, 0, 0, 0, 0);
    chk("retlw_unf", 32'(stk_unf), 1);
    chk("retlw_addr", 32'(rom_addr_out), 32'h181);
    cyc(0, 0, 0, 1, 11'h7FF);
    chk("unf_pulse", 32'(stk_unf), 0);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_addr", 32'(rom_addr_out), 0);

    // pc_load beats stall; stall holds; reset on a CALL fetch.
    cyc(0, 1, 0, 1, 11'h123);
    chk("load_addr", 32'(rom_addr_out), 32'h123);
    chk("load_valid", 32'(ir_valid), 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("stall_addr", 32'(rom_addr_out), 32'h123);
    cyc(1, 0, 0, 0, 0);
    chk("rstcall_addr", 32'(rom_addr_out), 0);
    chk("rstcall_valid", 32'(ir_valid), 0);
    cyc(0, 0, 0, 1, 11'h050);
    cyc(0, 0, 0, 0, 0);
    chk("rstcall_depth0", 32'(stk_unf), 1);
    cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
